// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: FETCH/DECODE/execute FSM driving datapath enables and mux selects.
// Define MIPS_MC_BNE_EN to add BNE (opcode 000101) to the branch path.
module mips_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [STATE_W-1:0] state,
    output logic               instr_done,
    output logic               illegal_op
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEM_ADDR = STATE_W'(2),
        MEM_RD   = STATE_W'(3),
        MEM_WB   = STATE_W'(4),
        MEM_WR   = STATE_W'(5),
        R_EXEC   = STATE_W'(6),
        R_WB     = STATE_W'(7),
        BRANCH   = STATE_W'(8),
        JUMP     = STATE_W'(9),
        I_EXEC   = STATE_W'(10),
        I_WB     = STATE_W'(11)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d    = FETCH;
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        pc_source  = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = R_EXEC;
`ifdef MIPS_MC_BNE_EN
                    OP_BEQ, OP_BNE: state_d = BRANCH;
`else
                    OP_BEQ:       state_d = BRANCH;
`endif
                    OP_J:         state_d = JUMP;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU:
                                  state_d = I_EXEC;
                    default: begin
                        // Unknown opcode: drop the instruction and refetch.
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? FETCH : MEM_WR;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b001;
                pc_source  = 2'b01;
                instr_done = 1'b1;
`ifdef MIPS_MC_BNE_EN
                pc_en      = (opcode == OP_BNE) ? ~zero : zero;
`else
                pc_en      = zero;
`endif
            end
            JUMP: begin
                pc_source  = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ANDI:           alu_op = 3'b100;
                    OP_ORI:            alu_op = 3'b101;
                    OP_SLTI, OP_SLTIU: alu_op = 3'b110;
                    default:           alu_op = 3'b000;
                endcase
                state_d = I_WB;
            end
            I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed scenarios with literal expectations, then random
// instruction streams checked every cycle against an instruction-plan model.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .state(state),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done, illegal_op;
    } outs_t;

    outs_t act_o;
    assign act_o = {pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
                    reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};

    int n_total = 0;
    int n_pass = 0;
    bit run_cmp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit is_bne_legal();
`ifdef MIPS_MC_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        if (op == 6'b000101) return is_bne_legal();
        return op inside {6'b000000, 6'b000010, 6'b000100, 6'b100011, 6'b101011,
                          6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101};
    endfunction

    // Total cycles of an instruction with zero-wait memory, FETCH included.
    function automatic int base_latency(input logic [5:0] op);
        if (!is_legal(op)) return 2;
        case (op)
            6'b100011: return 5;
            6'b000100, 6'b000101, 6'b000010: return 3;
            default: return 4;
        endcase
    endfunction

    // Expected outputs per state number, straight from the control table.
    function automatic outs_t exp_out(input int st, input logic [5:0] op, input logic z, input logic mr);
        outs_t o;
        o = '0;
        case (st)
            0: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_en = mr; end
            1: begin
                o.alu_src_b = 2'b11;
                if (!is_legal(op)) begin o.illegal_op = 1; o.instr_done = 1; end
            end
            2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3: begin o.mem_read = 1; o.i_or_d = 1; end
            4: begin o.mem_to_reg = 1; o.reg_write = 1; o.instr_done = 1; end
            5: begin o.mem_write = 1; o.i_or_d = 1; o.instr_done = mr; end
            6: begin o.alu_src_a = 1; o.alu_op = 3'b010; end
            7: begin o.reg_dst = 1; o.reg_write = 1; o.instr_done = 1; end
            8: begin
                o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_source = 2'b01; o.instr_done = 1;
                o.pc_en = (op == 6'b000101) ? ~z : z;
            end
            9: begin o.pc_source = 2'b10; o.pc_en = 1; o.instr_done = 1; end
            10: begin
                o.alu_src_a = 1; o.alu_src_b = 2'b10;
                if (op == 6'b001100) o.alu_op = 3'b100;
                else if (op == 6'b001101) o.alu_op = 3'b101;
                else if (op == 6'b001010 || op == 6'b001011) o.alu_op = 3'b110;
                else o.alu_op = 3'b000;
            end
            11: begin o.reg_write = 1; o.instr_done = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Model: current state plus the queue of states still to visit for this instruction.
    int m_state = 0;
    int m_prev = 0;
    int plan[$];
    int lat_cnt = 0;
    int stall_cnt = 0;

    always @(posedge clk) begin
        m_prev = m_state;
        if (!rst_n) begin
            m_state = 0;
            plan.delete();
            lat_cnt = 0;
            stall_cnt = 0;
        end else begin
            lat_cnt++;
            if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
                stall_cnt++;
            end else if (m_state == 0) begin
                m_state = 1;
                plan.delete();
                if (is_legal(opcode)) begin
                    case (opcode)
                        6'b100011: plan = '{2, 3, 4};
                        6'b101011: plan = '{2, 5};
                        6'b000000: plan = '{6, 7};
                        6'b000100, 6'b000101: plan = '{8};
                        6'b000010: plan = '{9};
                        default:   plan = '{10, 11};
                    endcase
                end
            end else if (plan.size() > 0) begin
                m_state = plan.pop_front();
            end else begin
                m_state = 0;
            end
            if (m_state == 0 && m_prev != 0) begin
                lat_cnt = 0;
                stall_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("state", 32'(state), 32'(m_state));
            check("outputs", 32'(act_o), 32'(exp_out(m_state, opcode, zero, mem_ready)));
            check("rw_excl", 32'(reg_write & mem_write), 32'd0);
            check("mem_excl", 32'(mem_read & mem_write), 32'd0);
            if (instr_done === 1'b1)
                check("latency", 32'(lat_cnt + 1), 32'(base_latency(opcode) + stall_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    logic [5:0] op_tab [0:11] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                                  6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0a, 6'h0b};

    initial begin
        // R-type with zero-wait memory: 0,1,6,7,0
        opcode = 6'b000000; mem_ready = 1'b1; zero = 1'b0;
        do_reset();
        run_cmp = 1'b1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd1);
        check("rst_pc_en", 32'(pc_en), 32'd1);
        check("rst_src_b", 32'(alu_src_b), 32'd1);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        cyc(); check("r_decode", 32'(state), 32'd1);
        cyc(); check("r_exec", 32'(state), 32'd6);
        check("r_exec_aluop", 32'(alu_op), 32'd2);
        check("r_exec_regw", 32'(reg_write), 32'd0);
        cyc(); check("r_wb", 32'(state), 32'd7);
        check("r_wb_regw", 32'(reg_write), 32'd1);
        check("r_wb_regdst", 32'(reg_dst), 32'd1);
        check("r_wb_done", 32'(instr_done), 32'd1);
        cyc(); check("r_back_fetch", 32'(state), 32'd0);

        // LW with two stall cycles in MEM_RD: 7 cycles total
        opcode = 6'b100011;
        cyc(); cyc(); cyc();
        check("lw_memrd", 32'(state), 32'd3);
        mem_ready = 1'b0;
        check("lw_memrd_m2r", 32'(mem_to_reg), 32'd0);
        cyc();
        check("lw_stall", 32'(state), 32'd3);
        cyc();
        check("lw_stall2", 32'(state), 32'd3);
        mem_ready = 1'b1;
        cyc();
        check("lw_memwb", 32'(state), 32'd4);
        check("lw_m2r", 32'(mem_to_reg), 32'd1);
        check("lw_regw", 32'(reg_write), 32'd1);
        cyc(); check("lw_back_fetch", 32'(state), 32'd0);

        // BEQ taken then not taken
        opcode = 6'b000100; zero = 1'b1;
        cyc(); cyc();
        check("beq_state", 32'(state), 32'd8);
        check("beq_taken_pc_en", 32'(pc_en), 32'd1);
        check("beq_pc_source", 32'(pc_source), 32'd1);
        check("beq_alu_op", 32'(alu_op), 32'd1);
        cyc(); zero = 1'b0;
        cyc(); cyc();
        check("beq_nt_state", 32'(state), 32'd8);
        check("beq_nt_pc_en", 32'(pc_en), 32'd0);
        cyc();

        // ORI then an illegal opcode
        opcode = 6'b001101;
        cyc(); cyc();
        check("ori_exec", 32'(state), 32'd10);
        check("ori_alu_op", 32'(alu_op), 32'd5);
        cyc(); cyc();
        check("ori_done_fetch", 32'(state), 32'd0);
        opcode = 6'b111111;
        cyc();
        check("ill_pulse", 32'(illegal_op), 32'd1);
        check("ill_done", 32'(instr_done), 32'd1);
        cyc();
        check("ill_fetch", 32'(state), 32'd0);
        check("ill_cleared", 32'(illegal_op), 32'd0);

        // BNE with zero=0
        opcode = 6'b000101; zero = 1'b0;
        cyc();
`ifdef MIPS_MC_BNE_EN
        check("bne_legal", 32'(illegal_op), 32'd0);
        cyc();
        check("bne_branch", 32'(state), 32'd8);
        check("bne_pc_en", 32'(pc_en), 32'd1);
`else
        check("bne_illegal", 32'(illegal_op), 32'd1);
        cyc();
        check("bne_no_branch", 32'(state), 32'd0);
`endif
        while (m_state != 0) cyc();

        // Reset during a MEM_WR stall abandons the store
        opcode = 6'b101011;
        cyc(); cyc(); cyc();
        check("sw_memwr", 32'(state), 32'd5);
        mem_ready = 1'b0;
        check("sw_mem_write", 32'(mem_write), 32'd1);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("sw_rst_state", 32'(state), 32'd0);
        check("sw_rst_mem_write", 32'(mem_write), 32'd0);
        check("sw_rst_mem_read", 32'(mem_read), 32'd1);
        mem_ready = 1'b1;

        // Random instruction stream with stalls, branch flags and occasional resets
        for (int i = 0; i < 5000; i++) begin
            if (m_state == 0)
                opcode = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 11)];
            mem_ready = ($urandom_range(0, 3) != 0);
            zero = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 249) != 0);
            cyc();
        end
        rst_n = 1'b1;
        cyc();
        run_cmp = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
